// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and command decoder for the HD44780-style
// bus responder.
package lcd_pkg;

    localparam logic [7:0] SPACE_CHAR = 8'h20;
    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE_END   = 7'h27;

    localparam logic [7:0] MASK_DDRAM = 8'h80;
    localparam logic [7:0] MASK_CGRAM = 8'h40;
    localparam logic [7:0] MASK_FUNC  = 8'h20;
    localparam logic [7:0] MASK_SHIFT = 8'h10;
    localparam logic [7:0] MASK_DISP  = 8'h08;
    localparam logic [7:0] MASK_ENTRY = 8'h04;
    localparam logic [7:0] MASK_HOME  = 8'h02;
    localparam logic [7:0] MASK_CLEAR = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        CMD_NOP, CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISP,
        CMD_SHIFT, CMD_FUNC, CMD_CGRAM, CMD_DDRAM
    } cmd_t;

    // The highest set bit selects the instruction.
    function automatic cmd_t decode_cmd(input logic [7:0] d);
        cmd_t res;
        res = CMD_NOP;
        if      ((d & MASK_DDRAM) != 8'h00) res = CMD_DDRAM;
        else if ((d & MASK_CGRAM) != 8'h00) res = CMD_CGRAM;
        else if ((d & MASK_FUNC)  != 8'h00) res = CMD_FUNC;
        else if ((d & MASK_SHIFT) != 8'h00) res = CMD_SHIFT;
        else if ((d & MASK_DISP)  != 8'h00) res = CMD_DISP;
        else if ((d & MASK_ENTRY) != 8'h00) res = CMD_ENTRY;
        else if ((d & MASK_HOME)  != 8'h00) res = CMD_HOME;
        else if ((d & MASK_CLEAR) != 8'h00) res = CMD_CLEAR;
        return res;
    endfunction

endpackage

// File: rtl/lcd_ac_map.sv
// Address-counter helper: visible-index mapping and next-AC with line wrap.
module lcd_ac_map
    import lcd_pkg::*;
(
    input  logic [6:0] ac,
    input  logic       dir,
    output logic       valid,
    output logic [4:0] idx,
    output logic [6:0] ac_next
);

    always_comb begin
        valid = (ac[6:4] == LINE1_BASE[6:4]) || (ac[6:4] == LINE2_BASE[6:4]);
        idx   = {ac[6], ac[3:0]};
        // Out-of-range addresses step modulo 128 without any line wrap.
        if (dir) begin
            if (ac == LINE_END)                   ac_next = LINE2_BASE;
            else if (ac == LINE2_BASE + LINE_END) ac_next = LINE1_BASE;
            else                                  ac_next = ac + 7'd1;
        end else begin
            if (ac == LINE1_BASE)                 ac_next = LINE2_BASE + LINE_END;
            else if (ac == LINE2_BASE)            ac_next = LINE_END;
            else                                  ac_next = ac - 7'd1;
        end
    end

endmodule

// File: rtl/lcd_bus_responder.sv
// Character-LCD bus responder with 2x16 DDRAM and decoded mode flags.
// Define LCD_BUS_RESP_READ_EN to add RW=1 read support (LCD_DOUT/LCD_DOE).
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int EXEC_CYCLES  = 0,
    parameter int CLEAR_CYCLES = 150
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DATA,
`ifdef LCD_BUS_RESP_READ_EN
    output logic [7:0] LCD_DOUT,
    output logic       LCD_DOE,
`endif
    input  logic [4:0] RD_IDX,
    output logic [7:0] RD_CHAR,
    output logic [6:0] AC,
    output logic       BUSY,
    output logic       DISP_ON,
    output logic       CURSOR_ON,
    output logic       BLINK_ON,
    output logic       TWO_LINE,
    output logic       INC_MODE,
    output logic       OVERRUN
);

    localparam int          CLR_TOTAL = (CLEAR_CYCLES > 32) ? CLEAR_CYCLES : 32;
    localparam logic [15:0] CLR_LOAD  = 16'(CLR_TOTAL - 1);
    localparam logic [15:0] EXEC_LOAD = 16'((EXEC_CYCLES > 0) ? EXEC_CYCLES - 1 : 0);

    logic [10:0] bus_in;
    assign bus_in = {LCD_E, LCD_RS, LCD_RW, LCD_DATA};

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic [10:0] stage_reg;
        if (gi == 0) begin : g_first
            always_ff @(posedge CLK or posedge RESET)
                if (RESET) stage_reg <= '0;
                else       stage_reg <= bus_in;
        end else begin : g_rest
            always_ff @(posedge CLK or posedge RESET)
                if (RESET) stage_reg <= '0;
                else       stage_reg <= g_sync[gi-1].stage_reg;
        end
    end

    logic       e_s, rs_s, rw_s;
    logic [7:0] data_s;
    assign {e_s, rs_s, rw_s, data_s} = g_sync[SYNC_STAGES-1].stage_reg;

    logic       e_prev_reg, rs_reg, rw_reg;
    logic [7:0] data_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            e_prev_reg <= 1'b0;
            rs_reg     <= 1'b0;
            rw_reg     <= 1'b0;
            data_reg   <= '0;
        end else begin
            e_prev_reg <= e_s;
            if (e_s) begin
                rs_reg   <= rs_s;
                rw_reg   <= rw_s;
                data_reg <= data_s;
            end
        end
    end

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg;
    logic [6:0]  ac_reg;
    logic        inc_reg, disp_reg, cursor_reg, blink_reg, two_reg, overrun_reg;
    logic [5:0]  clr_idx_reg;
    logic [7:0]  ddram [32];
    logic [7:0]  rd_char_reg;

    logic xfer, idle, is_cmd, is_wr, is_rd, counted;
    logic do_cmd, do_wr, do_rd, go_clear, go_exec;
    cmd_t cmd;
    logic       map_dir, map_valid;
    logic [4:0] map_idx;
    logic [6:0] map_next;

    always_comb begin
        xfer   = e_prev_reg & ~e_s;
        idle   = (state_reg == ST_IDLE);
        cmd    = decode_cmd(data_reg);
        is_cmd = xfer & ~rs_reg & ~rw_reg;
        is_wr  = xfer &  rs_reg & ~rw_reg;
`ifdef LCD_BUS_RESP_READ_EN
        is_rd   = xfer & rs_reg & rw_reg;
        // Status reads are how the host polls BUSY, so they never overrun.
        counted = xfer & ~(rw_reg & ~rs_reg);
`else
        is_rd   = 1'b0;
        counted = xfer & ~rw_reg;
`endif
        do_cmd   = is_cmd & idle;
        do_wr    = is_wr & idle;
        do_rd    = is_rd & idle;
        go_clear = do_cmd && (cmd == CMD_CLEAR);
        go_exec  = (EXEC_CYCLES > 0) &&
                   ((do_cmd && cmd != CMD_NOP && cmd != CMD_CLEAR) || do_wr);
        map_dir  = (do_cmd && cmd == CMD_SHIFT) ? data_reg[2] : inc_reg;
    end

    lcd_ac_map u_ac_map (
        .ac      (ac_reg),
        .dir     (map_dir),
        .valid   (map_valid),
        .idx     (map_idx),
        .ac_next (map_next)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (go_clear)     state_next = ST_CLEAR;
                else if (go_exec) state_next = ST_EXEC;
            end
            ST_EXEC, ST_CLEAR: begin
                if (cnt_reg == 16'd0) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state_reg != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                cnt_reg <= '0;
        else if (go_clear)        cnt_reg <= CLR_LOAD;
        else if (go_exec)         cnt_reg <= EXEC_LOAD;
        else if (cnt_reg != 16'd0) cnt_reg <= cnt_reg - 16'd1;
    end

    logic       wr_en;
    logic [4:0] wr_idx;
    logic [7:0] wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = map_idx;
        wr_data = data_reg;
        if (state_reg == ST_CLEAR && !clr_idx_reg[5]) begin
            wr_en   = 1'b1;
            wr_idx  = clr_idx_reg[4:0];
            wr_data = SPACE_CHAR;
        end else if (do_wr && map_valid) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ac_reg      <= '0;
            inc_reg     <= 1'b1;
            disp_reg    <= 1'b0;
            cursor_reg  <= 1'b0;
            blink_reg   <= 1'b0;
            two_reg     <= 1'b0;
            overrun_reg <= 1'b0;
            clr_idx_reg <= '0;
        end else begin
            if (counted && BUSY) overrun_reg <= 1'b1;
            if (do_wr || do_rd)  ac_reg <= map_next;
            if (do_cmd) begin
                case (cmd)
                    CMD_DDRAM: ac_reg <= data_reg[6:0];
                    CMD_FUNC:  two_reg <= data_reg[3];
                    CMD_SHIFT: if (!data_reg[3]) ac_reg <= map_next;
                    CMD_DISP:  {disp_reg, cursor_reg, blink_reg} <= data_reg[2:0];
                    CMD_ENTRY: inc_reg <= data_reg[1];
                    CMD_HOME:  ac_reg <= '0;
                    default: ;
                endcase
            end
            if (go_clear) begin
                ac_reg      <= '0;
                inc_reg     <= 1'b1;
                clr_idx_reg <= '0;
            end else if (state_reg == ST_CLEAR && !clr_idx_reg[5]) begin
                clr_idx_reg <= clr_idx_reg + 6'd1;
            end
        end
    end

    // Registered read returns the pre-write value on a same-cycle collision.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) ddram[i] <= SPACE_CHAR;
            rd_char_reg <= SPACE_CHAR;
        end else begin
            if (wr_en) ddram[wr_idx] <= wr_data;
            rd_char_reg <= ddram[RD_IDX];
        end
    end

`ifdef LCD_BUS_RESP_READ_EN
    always_comb begin
        LCD_DOE  = e_s & rw_s;
        LCD_DOUT = '0;
        if (LCD_DOE)
            LCD_DOUT = rs_s ? (map_valid ? ddram[map_idx] : SPACE_CHAR) : {BUSY, ac_reg};
    end
`endif

    assign RD_CHAR   = rd_char_reg;
    assign AC        = ac_reg;
    assign DISP_ON   = disp_reg;
    assign CURSOR_ON = cursor_reg;
    assign BLINK_ON  = blink_reg;
    assign TWO_LINE  = two_reg;
    assign INC_MODE  = inc_reg;
    assign OVERRUN   = overrun_reg;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: command/data vector table plus
// hand sequences for latency, clear/busy/overrun and reset-during-clear.
module tb_lcd_bus_responder;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       LCD_E = 1'b0, LCD_RS = 1'b0, LCD_RW = 1'b0;
    logic [7:0] LCD_DATA = 8'h00;
    logic [4:0] RD_IDX = 5'd0;
    logic [7:0] RD_CHAR;
    logic [6:0] AC;
    logic       BUSY, DISP_ON, CURSOR_ON, BLINK_ON, TWO_LINE, INC_MODE, OVERRUN;
`ifdef LCD_BUS_RESP_READ_EN
    logic [7:0] LCD_DOUT;
    logic       LCD_DOE;
`endif

    lcd_bus_responder #(.SYNC_STAGES(2), .EXEC_CYCLES(0), .CLEAR_CYCLES(150)) dut (
        .CLK(CLK), .RESET(RESET),
        .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA),
`ifdef LCD_BUS_RESP_READ_EN
        .LCD_DOUT(LCD_DOUT), .LCD_DOE(LCD_DOE),
`endif
        .RD_IDX(RD_IDX), .RD_CHAR(RD_CHAR), .AC(AC), .BUSY(BUSY),
        .DISP_ON(DISP_ON), .CURSOR_ON(CURSOR_ON), .BLINK_ON(BLINK_ON),
        .TWO_LINE(TWO_LINE), .INC_MODE(INC_MODE), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [6:0] ac;
        logic [4:0] flags;   // {DISP_ON, CURSOR_ON, BLINK_ON, TWO_LINE, INC_MODE}
    } vec_t;

    vec_t vecs[33];

    typedef struct {
        logic [4:0] idx;
        logic [7:0] ch;
    } rb_t;

    rb_t rbs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {DISP_ON, CURSOR_ON, BLINK_ON, TWO_LINE, INC_MODE};
    endfunction

    task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] data);
        @(negedge CLK);
        LCD_RS = rs; LCD_RW = rw; LCD_DATA = data; LCD_E = 1'b1;
        repeat (2) @(negedge CLK);
        LCD_E = 1'b0;
        repeat (5) @(negedge CLK);
        $display("xfer rs=%0b rw=%0b data=0x%02h -> ac=0x%02h flags=%05b busy=%0b",
                 rs, rw, data, AC, flags(), BUSY);
    endtask

    task automatic readback(input logic [4:0] idx, input logic [7:0] exp);
        @(negedge CLK);
        RD_IDX = idx;
        @(negedge CLK);
        $display("read idx=%0d char=0x%02h", idx, RD_CHAR);
        chk($sformatf("rd_idx%0d", idx), RD_CHAR, exp);
    endtask

    initial begin
        int busy_cnt;
        int first_busy;
        int to;

        vecs[0]  = '{1'b0, 8'h3C, 7'h00, 5'b00011};
        vecs[1]  = '{1'b0, 8'h0C, 7'h00, 5'b10011};
        vecs[2]  = '{1'b0, 8'h06, 7'h00, 5'b10011};
        vecs[3]  = '{1'b0, 8'h80, 7'h00, 5'b10011};
        vecs[4]  = '{1'b1, 8'h31, 7'h01, 5'b10011};
        vecs[5]  = '{1'b1, 8'h32, 7'h02, 5'b10011};
        vecs[6]  = '{1'b1, 8'h3A, 7'h03, 5'b10011};
        vecs[7]  = '{1'b1, 8'h33, 7'h04, 5'b10011};
        vecs[8]  = '{1'b1, 8'h34, 7'h05, 5'b10011};
        vecs[9]  = '{1'b0, 8'hC0, 7'h40, 5'b10011};
        vecs[10] = '{1'b1, 8'h41, 7'h41, 5'b10011};
        vecs[11] = '{1'b0, 8'hA7, 7'h27, 5'b10011};
        vecs[12] = '{1'b1, 8'h55, 7'h40, 5'b10011};
        vecs[13] = '{1'b0, 8'hE7, 7'h67, 5'b10011};
        vecs[14] = '{1'b1, 8'h66, 7'h00, 5'b10011};
        vecs[15] = '{1'b0, 8'h04, 7'h00, 5'b10010};
        vecs[16] = '{1'b0, 8'h80, 7'h00, 5'b10010};
        vecs[17] = '{1'b1, 8'h77, 7'h67, 5'b10010};
        vecs[18] = '{1'b0, 8'h14, 7'h00, 5'b10010};
        vecs[19] = '{1'b0, 8'h10, 7'h67, 5'b10010};
        vecs[20] = '{1'b0, 8'h18, 7'h67, 5'b10010};
        vecs[21] = '{1'b0, 8'h0F, 7'h67, 5'b11110};
        vecs[22] = '{1'b0, 8'h02, 7'h00, 5'b11110};
        vecs[23] = '{1'b0, 8'h40, 7'h00, 5'b11110};
        vecs[24] = '{1'b0, 8'h00, 7'h00, 5'b11110};
        vecs[25] = '{1'b0, 8'hFF, 7'h7F, 5'b11110};
        vecs[26] = '{1'b0, 8'h06, 7'h7F, 5'b11111};
        vecs[27] = '{1'b1, 8'h11, 7'h00, 5'b11111};
        vecs[28] = '{1'b0, 8'h20, 7'h00, 5'b11101};
        vecs[29] = '{1'b0, 8'h38, 7'h00, 5'b11111};
        vecs[30] = '{1'b0, 8'h05, 7'h00, 5'b11110};
        vecs[31] = '{1'b1, 8'h22, 7'h67, 5'b11110};
        vecs[32] = '{1'b0, 8'h04, 7'h67, 5'b11110};

        rbs[0]  = '{5'd0,  8'h22};
        rbs[1]  = '{5'd1,  8'h32};
        rbs[2]  = '{5'd2,  8'h3A};
        rbs[3]  = '{5'd3,  8'h33};
        rbs[4]  = '{5'd4,  8'h34};
        rbs[5]  = '{5'd5,  8'h20};
        rbs[6]  = '{5'd7,  8'h20};
        rbs[7]  = '{5'd16, 8'h41};
        rbs[8]  = '{5'd17, 8'h20};
        rbs[9]  = '{5'd23, 8'h20};
        rbs[10] = '{5'd31, 8'h20};

        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_ac", AC, 7'h00);
        chk("rst_flags", flags(), 5'b00001);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_overrun", OVERRUN, 1'b0);
        chk("rst_rdchar", RD_CHAR, 8'h20);

        for (int i = 0; i < 33; i++) begin
            bus_xfer(vecs[i].rs, 1'b0, vecs[i].data);
            chk($sformatf("v%0d_ac", i), AC, vecs[i].ac);
            chk($sformatf("v%0d_flags", i), flags(), vecs[i].flags);
            chk($sformatf("v%0d_busy", i), BUSY, 1'b0);
        end

        for (int i = 0; i < 11; i++) readback(rbs[i].idx, rbs[i].ch);

        // Update must appear exactly SYNC_STAGES+1 edges after E falls.
        @(negedge CLK);
        LCD_RS = 1'b0; LCD_DATA = 8'h85; LCD_E = 1'b1;
        repeat (2) @(negedge CLK);
        LCD_E = 1'b0;
        @(negedge CLK); chk("lat_edge1", AC, 7'h67);
        @(negedge CLK); chk("lat_edge2", AC, 7'h67);
        @(negedge CLK); chk("lat_edge3", AC, 7'h05);
        $display("xfer rs=0 rw=0 data=0x85 latency sequence ac=0x%02h", AC);

        // Clear: count BUSY cycles and inject a data write while busy.
        @(negedge CLK);
        LCD_RS = 1'b0; LCD_DATA = 8'h01; LCD_E = 1'b1;
        repeat (2) @(negedge CLK);
        LCD_E = 1'b0;
        busy_cnt = 0;
        first_busy = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (BUSY) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = i;
            end
            if (i == 20) begin LCD_RS = 1'b1; LCD_DATA = 8'h99; LCD_E = 1'b1; end
            if (i == 23) LCD_E = 1'b0;
        end
        $display("xfer rs=0 rw=0 data=0x01 clear busy_cycles=%0d overrun=%0b", busy_cnt, OVERRUN);
        chk("clr_busy_start", first_busy, 2);
        chk("clr_busy_len", busy_cnt, 150);
        chk("clr_busy_end", BUSY, 1'b0);
        chk("clr_overrun", OVERRUN, 1'b1);
        chk("clr_ac", AC, 7'h00);
        chk("clr_flags", flags(), 5'b11111);
        for (int i = 0; i < 32; i++) readback(5'(i), 8'h20);

        bus_xfer(1'b1, 1'b0, 8'h48);
        chk("post_clr_ac", AC, 7'h01);
        chk("post_clr_overrun", OVERRUN, 1'b1);
        readback(5'd0, 8'h48);

        // Reset in the middle of a clear restores every reset value.
        bus_xfer(1'b0, 1'b0, 8'hCF);
        bus_xfer(1'b1, 1'b0, 8'h5A);
        readback(5'd31, 8'h5A);
        bus_xfer(1'b0, 1'b0, 8'h01);
        chk("midclr_busy", BUSY, 1'b1);
        @(negedge CLK); RESET = 1'b1;
        @(negedge CLK); RESET = 1'b0;
        @(negedge CLK);
        chk("midclr_rst_busy", BUSY, 1'b0);
        chk("midclr_rst_overrun", OVERRUN, 1'b0);
        chk("midclr_rst_ac", AC, 7'h00);
        chk("midclr_rst_flags", flags(), 5'b00001);
        readback(5'd31, 8'h20);
        bus_xfer(1'b0, 1'b0, 8'h0C);
        chk("after_rst_disp", flags(), 5'b10001);

`ifdef LCD_BUS_RESP_READ_EN
        bus_xfer(1'b0, 1'b0, 8'h01);
        @(negedge CLK);
        LCD_RS = 1'b0; LCD_RW = 1'b1; LCD_E = 1'b1;
        repeat (4) @(negedge CLK);
        chk("rd_busy_doe", LCD_DOE, 1'b1);
        chk("rd_busy_dout", LCD_DOUT, 8'h80);
        LCD_E = 1'b0;
        to = 0;
        while (BUSY && to < 400) begin @(negedge CLK); to++; end
        chk("rd_wait_busy", BUSY, 1'b0);
        LCD_RW = 1'b0;
        @(negedge CLK);
        LCD_RW = 1'b1; LCD_E = 1'b1;
        repeat (4) @(negedge CLK);
        chk("rd_idle_dout", LCD_DOUT, 8'h00);
        LCD_E = 1'b0;
        repeat (4) @(negedge CLK);
        LCD_RW = 1'b0;
        chk("rd_overrun", OVERRUN, 1'b0);
        $display("xfer status reads done dout=0x%02h", LCD_DOUT);
`else
        to = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_bus_responder.md
# lcd_bus_responder

Synthesizable HD44780-style character-LCD module that sits on the far end of the LCD_E/LCD_RS/LCD_RW/LCD_DATA bus driven by the display controller. It decodes the command and data writes, maintains a 2×16 display RAM, and exposes that RAM plus the decoded mode flags. This gives on-chip loopback checking and a bench-side reference for the alarm-clock display path.

## Interface
- SYNC_STAGES, 2: synchronizer depth on all bus inputs (≥2).
- EXEC_CYCLES, 0: BUSY hold after a normal command or data write (0 = no busy).
- CLEAR_CYCLES, 150: total BUSY hold after Clear Display (effective value is max(CLEAR_CYCLES, 32)).
- CLK  in  1  block clock; every flop uses the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- LCD_E, LCD_RS, LCD_RW  in  1  bus strobe, register select, read/write.
- LCD_DATA  in  8  bus data.
- LCD_DOUT  out  8  read data; present only with read support compiled in.
- LCD_DOE  out  1  read-data enable; present only with read support compiled in.
- RD_IDX  in  5  character index to read back: 0–15 is line 1, 16–31 is line 2.
- RD_CHAR  out  8  DDRAM[RD_IDX], registered, 1-cycle latency.
- AC  out  7  address counter.
- BUSY  out  1  command execution in progress.
- DISP_ON, CURSOR_ON, BLINK_ON, TWO_LINE, INC_MODE  out  1  decoded flags.
- OVERRUN  out  1  sticky flag: a transfer arrived while BUSY.

## Operation
- All bus inputs pass through SYNC_STAGES flops.
- A transfer is the synchronized E sequence 1→0. RS, RW and DATA are taken from the last E=1 sample.
- Decoding applies to RS=0, RW=0, priority by the highest set DATA bit:
  - 1xxxxxxx: AC=DATA[6:0].
  - 01xxxxxx: CGRAM address; ignored, but counts as a command for busy timing.
  - 001xxxxx: TWO_LINE=DATA[3].
  - 0001xxxx: cursor shift. If DATA[3]=0, AC steps by the DATA[2] direction (1=+1). If DATA[3]=1 (display shift), ignored.
  - 00001xxx: DISP_ON/CURSOR_ON/BLINK_ON = DATA[2:0].
  - 000001xx: INC_MODE=DATA[1]. The S bit is ignored.
  - 0000001x: AC=0.
  - 00000001: Clear Display.
  - 00000000: no-op with no busy time.
- Data write (RS=1, RW=0): if AC maps into the visible range, DDRAM[map(AC)]=DATA. AC then steps per INC_MODE.
- Address map:
  - AC 0x00–0x0F maps to index 0–15; AC 0x40–0x4F maps to index 16–31.
  - Writes to any other AC value are discarded, but AC still steps.
- AC stepping:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
  - A DDRAM-address command outside 0x00–0x27 or 0x40–0x67 is loaded as-is. The next step from it is +1/−1 modulo 128 with no line wrap.
- FSM states:
  - IDLE: on a transfer, execute it. If EXEC_CYCLES>0, go to EXEC; Clear Display goes to CLEAR.
  - EXEC: count down EXEC_CYCLES, then return to IDLE.
  - CLEAR: write 0x20 to index 0..31, one per cycle, set AC=0 and INC_MODE=1, then hold until max(CLEAR_CYCLES, 32) cycles have elapsed, then go to IDLE.
- BUSY=1 in EXEC and CLEAR.
- A transfer while BUSY is dropped and sets OVERRUN. OVERRUN clears only on reset.
- If a transfer coincides with the last BUSY cycle, it is dropped.
- Reset values:
  - DDRAM all 0x20, AC=0, INC_MODE=1, other flags 0, BUSY=0, OVERRUN=0, RD_CHAR=0x20.
  - With read support: LCD_DOUT=0, LCD_DOE=0.
- RESET mid-CLEAR aborts the clear; the reset values above apply.

## Timing
- Bus E falling edge to flag, AC or DDRAM update: SYNC_STAGES+1 CLK cycles.
- BUSY rises in that same cycle.
- The controller must hold E high and E low for at least 1 CLK period each.
- RD_CHAR is valid 1 cycle after RD_IDX changes. When a write and a readback hit the same index, RD_CHAR returns the old value that cycle.

## Configuration
- LCD_BUS_RESP_READ_EN defined:
  - RW=1 transfers are supported.
  - RS=0 returns {BUSY, AC} on LCD_DOUT. RS=1 returns DDRAM[map(AC)] (0x20 if unmapped), then AC steps.
  - LCD_DOE is high from the cycle E=1 is seen synchronized with RW=1 until the falling-edge detect.
- Undefined:
  - RW=1 transfers are ignored and do not set OVERRUN.
  - LCD_DOUT and LCD_DOE ports are absent.

## Structure
- Package lcd_pkg holds:
  - Command prefix masks.
  - SPACE_CHAR=8'h20.
  - LINE1_BASE=7'h00, LINE2_BASE=7'h40, LINE_END=7'h27.
  - FSM state encoding (IDLE/EXEC/CLEAR).
- Sub-module lcd_ac_map: combinational mapping from AC to {valid, idx[4:0]} and from (AC, dir) to next AC with the line wrap.

## Test plan
- Reset, then 0x3C, 0x0C, 0x06, 0x80, data "12:34" → DISP_ON=1, TWO_LINE=1, INC_MODE=1, RD_CHAR idx0–4 = 0x31,0x32,0x3A,0x33,0x34, AC=0x05.
- 0xC0 then 0x41 → DDRAM idx16=0x41, AC=0x41.
- AC=0x27, data write → AC=0x40, no DDRAM change. AC=0x67, write → AC=0x00.
- Entry mode 0x04, AC=0x00, write → AC=0x67.
- Clear 0x01 with CLEAR_CYCLES=150 → BUSY high exactly 150 cycles, all idx read 0x20, AC=0. A write during BUSY is dropped and sets OVERRUN=1.
- Read support: 0x01 then RS=0/RW=1 read while busy → LCD_DOUT=0x80. After BUSY falls → 0x00.
